// File: rtl/router_pkt_gen.sv
// Packet source for the 1x3 router: turns one command into header, payload and parity bytes,
// holding the bus under busy, then samples router err for ERR_WAIT cycles before accepting more.
module router_pkt_gen #(
    parameter int ERR_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_addr,
    input  logic [5:0]       cmd_len,
    input  logic             cmd_mode,
    input  logic [7:0]       cmd_seed,
    input  logic             busy,
    input  logic             err,
    output logic [7:0]       data_out,
    output logic             pkt_valid,
    output logic             cmd_err,
    output logic             done,
    output logic             pkt_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [7:0]       err_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        PARITY  = 3'd3,
        ERRWAIT = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         data_out_nxt;
    logic               pkt_valid_nxt, cmd_err_nxt, done_nxt, pkt_err_nxt;
    logic [CNT_W-1:0]   pkt_count_nxt;
    logic [7:0]         err_count_nxt;
    logic [7:0]         lfsr, lfsr_nxt;      // payload byte currently on the bus
    logic [7:0]         parity, parity_nxt;
    logic [5:0]         rem, rem_nxt;
    logic [5:0]         len, len_nxt;
    logic               mode, mode_nxt;
    logic [3:0]         wcnt, wcnt_nxt;
    logic               err_seen, err_seen_nxt;
    logic [7:0]         next_pl;
    logic               seen;

    // Successor of the current payload byte: increment or Fibonacci LFSR step.
    assign next_pl   = mode ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]}
                            : lfsr + 8'd1;
    assign cmd_ready = (state == IDLE);
    assign seen      = err_seen | err;

    always_comb begin
        state_nxt     = state;
        data_out_nxt  = data_out;
        pkt_valid_nxt = pkt_valid;
        cmd_err_nxt   = 1'b0;
        done_nxt      = 1'b0;
        pkt_err_nxt   = pkt_err;
        pkt_count_nxt = pkt_count;
        err_count_nxt = err_count;
        lfsr_nxt      = lfsr;
        parity_nxt    = parity;
        rem_nxt       = rem;
        len_nxt       = len;
        mode_nxt      = mode;
        wcnt_nxt      = wcnt;
        err_seen_nxt  = err_seen;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
                        cmd_err_nxt = 1'b1;
                    end else begin
                        len_nxt       = cmd_len;
                        mode_nxt      = cmd_mode;
                        // An all-zero LFSR would lock up, so seed 0 becomes 1 in LFSR mode.
                        lfsr_nxt      = (cmd_mode && cmd_seed == 8'd0) ? 8'd1 : cmd_seed;
                        pkt_err_nxt   = 1'b0;
                        data_out_nxt  = {cmd_len, cmd_addr};
                        pkt_valid_nxt = 1'b1;
                        state_nxt     = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    parity_nxt   = data_out;
                    rem_nxt      = len;
                    data_out_nxt = lfsr;
                    state_nxt    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    parity_nxt = parity ^ data_out;
                    rem_nxt    = rem - 6'd1;
                    if (rem == 6'd1) begin
                        data_out_nxt  = parity ^ data_out;
                        pkt_valid_nxt = 1'b0;
                        state_nxt     = PARITY;
                    end else begin
                        lfsr_nxt     = next_pl;
                        data_out_nxt = next_pl;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    data_out_nxt = 8'd0;
                    wcnt_nxt     = 4'(ERR_WAIT);
                    err_seen_nxt = 1'b0;
                    state_nxt    = ERRWAIT;
                end
            end
            ERRWAIT: begin
                err_seen_nxt = seen;
                if (wcnt <= 4'd1) begin
                    wcnt_nxt      = 4'd0;
                    done_nxt      = 1'b1;
                    pkt_count_nxt = pkt_count + CNT_W'(1);
                    pkt_err_nxt   = seen;
                    if (seen && err_count != 8'hFF)
                        err_count_nxt = err_count + 8'd1;
                    state_nxt     = IDLE;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            data_out  <= 8'd0;
            pkt_valid <= 1'b0;
            cmd_err   <= 1'b0;
            done      <= 1'b0;
            pkt_err   <= 1'b0;
            pkt_count <= '0;
            err_count <= 8'd0;
            lfsr      <= 8'd0;
            parity    <= 8'd0;
            rem       <= 6'd0;
            len       <= 6'd0;
            mode      <= 1'b0;
            wcnt      <= 4'd0;
            err_seen  <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_out  <= data_out_nxt;
            pkt_valid <= pkt_valid_nxt;
            cmd_err   <= cmd_err_nxt;
            done      <= done_nxt;
            pkt_err   <= pkt_err_nxt;
            pkt_count <= pkt_count_nxt;
            err_count <= err_count_nxt;
            lfsr      <= lfsr_nxt;
            parity    <= parity_nxt;
            rem       <= rem_nxt;
            len       <= len_nxt;
            mode      <= mode_nxt;
            wcnt      <= wcnt_nxt;
            err_seen  <= err_seen_nxt;
        end
    end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Bench for router_pkt_gen: expected bus bytes are queued per command and compared as the DUT emits them.
module tb_router_pkt_gen;

    localparam int ERR_WAIT = 3;
    localparam int CNT_W    = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready, cmd_mode, busy, err;
    logic [1:0]       cmd_addr;
    logic [5:0]       cmd_len;
    logic [7:0]       cmd_seed, data_out, err_count;
    logic             pkt_valid, cmd_err, done, pkt_err;
    logic [CNT_W-1:0] pkt_count;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_pkts = 0;
    int         exp_errs = 0;
    logic [8:0] exp_q[$];
    logic       in_pkt = 1'b0;

    always #5 clock = ~clock;

    router_pkt_gen #(.ERR_WAIT(ERR_WAIT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_mode(cmd_mode), .cmd_seed(cmd_seed),
        .busy(busy), .err(err),
        .data_out(data_out), .pkt_valid(pkt_valid),
        .cmd_err(cmd_err), .done(done), .pkt_err(pkt_err),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic m, input logic [7:0] s, input int idx);
        logic [7:0] b;
        b = (m && s == 8'd0) ? 8'd1 : s;
        for (int i = 0; i < idx; i++)
            b = m ? {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]} : b + 8'd1;
        return b;
    endfunction

    function automatic void push_pkt(input logic [1:0] a, input logic [5:0] l,
                                     input logic m, input logic [7:0] s);
        logic [7:0] p, b;
        p = {l, a};
        exp_q.push_back({1'b1, l, a});
        for (int k = 0; k < int'(l); k++) begin
            b = byte_at(m, s, k);
            exp_q.push_back({1'b1, b});
            p = p ^ b;
        end
        exp_q.push_back({1'b0, p});
    endfunction

    // Bus monitor: each byte presented while busy is low counts as accepted.
    always @(negedge clock) begin
        if (reset) begin
            in_pkt = 1'b0;
            exp_q.delete();
        end else if (!busy && (pkt_valid || in_pkt)) begin
            if (exp_q.size() == 0)
                check("sb_empty", 32'(exp_q.size()), 32'd1);
            else
                check("bus", 32'({pkt_valid, data_out}), 32'(exp_q.pop_front()));
            in_pkt = pkt_valid;
        end
    end

    // Called and returns at #1 after a rising edge; leaves the accept edge just behind.
    task automatic start_cmd(input logic [1:0] a, input logic [5:0] l,
                             input logic m, input logic [7:0] s);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        if (t == 200) check("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_mode  = m;
        cmd_seed  = s;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    // k counts edges since command acceptance; busy/err set at phase k are sampled at edge k+1.
    task automatic send(input logic [1:0] a, input logic [5:0] l, input logic m, input logic [7:0] s,
                        input int b0, input int bn, input int ed, input logic exp_perr);
        int k = 0;
        push_pkt(a, l, m, s);
        start_cmd(a, l, m, s);
        check("hdr_timing", 32'({pkt_valid, data_out}), 32'({1'b1, l, a}));
        check("rdy_in_pkt", 32'(cmd_ready), 32'd0);
        check("perr_clear", 32'(pkt_err), 32'd0);
        while (!done && k < 300) begin
            busy = (bn > 0 && k >= b0 && k < b0 + bn);
            err  = (ed > 0 && k == int'(l) + 1 + ed + bn);
            if (bn > 0 && k > b0 && k <= b0 + bn)
                check("hold", 32'({pkt_valid, data_out}), 32'({1'b1, byte_at(m, s, b0 - 1)}));
            @(posedge clock); #1;
            k++;
        end
        busy = 1'b0;
        err  = 1'b0;
        exp_pkts++;
        if (exp_perr && exp_errs < 255) exp_errs++;
        check("done", 32'(done), 32'd1);
        check("cycles", 32'(k), 32'(int'(l) + 2 + ERR_WAIT + bn));
        check("pkt_err", 32'(pkt_err), 32'(exp_perr));
        check("pkt_count", 32'(pkt_count), 32'(exp_pkts));
        check("err_count", 32'(err_count), 32'(exp_errs));
        @(posedge clock); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("ready_back", 32'(cmd_ready), 32'd1);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
        cmd_mode = 1'b0; cmd_seed = 8'd0; busy = 1'b0; err = 1'b0;
        #1;
        check("rst_bus", 32'({pkt_valid, data_out}), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_pulses", 32'({cmd_err, done, pkt_err}), 32'd0);
        check("rst_counts", 32'({pkt_count, err_count}), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        send(2'd1, 6'd3, 1'b0, 8'h10, 0, 0, 0, 1'b0);       // 0D 10 11 12 / 1E
        send(2'd0, 6'd2, 1'b0, 8'hFF, 0, 0, 0, 1'b0);       // 08 FF 00 / F7
        send(2'd1, 6'd3, 1'b0, 8'h10, 2, 3, 0, 1'b0);       // busy while 11 presented
        send(2'd2, 6'd6, 1'b1, 8'h00, 0, 0, 0, 1'b0);       // LFSR, zero seed
        send(2'd2, 6'd5, 1'b1, 8'hA5, 3, 2, 0, 1'b0);       // LFSR under backpressure
        send(2'd1, 6'd63, 1'b0, 8'hC8, 0, 0, 0, 1'b0);      // max length

        for (int i = 0; i < 2; i++) begin
            if (i == 0) start_cmd(2'd3, 6'd4, 1'b0, 8'h00);
            else        start_cmd(2'd2, 6'd0, 1'b0, 8'h00);
            check("cmd_err", 32'(cmd_err), 32'd1);
            check("ill_bus", 32'({pkt_valid, data_out}), 32'd0);
            @(posedge clock); #1;
            check("cmd_err_pulse", 32'(cmd_err), 32'd0);
            check("ill_ready", 32'(cmd_ready), 32'd1);
        end
        check("ill_count", 32'(pkt_count), 32'(exp_pkts));

        send(2'd2, 6'd4, 1'b0, 8'h30, 0, 0, 2, 1'b1);       // err two cycles after parity
        send(2'd0, 6'd1, 1'b1, 8'h80, 0, 0, 0, 1'b0);       // clean packet clears pkt_err

        push_pkt(2'd1, 6'd5, 1'b1, 8'h3C);
        start_cmd(2'd1, 6'd5, 1'b1, 8'h3C);
        repeat (3) begin
            @(posedge clock); #1;
        end
        #2 reset = 1'b1;
        #1;
        check("arst_bus", 32'({pkt_valid, data_out}), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        check("arst_counts", 32'({pkt_count, err_count}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        exp_pkts = 0;
        exp_errs = 0;
        send(2'd1, 6'd3, 1'b0, 8'h10, 0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
